// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: opcode/state types and default timing for the NAND bus sequencer.
// The optional busy timeout is compiled in with NAND_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
package nand_seq_pkg;

    typedef enum logic [2:0] {
        OP_CMD     = 3'd0,
        OP_ADDR    = 3'd1,
        OP_WDATA   = 3'd2,
        OP_RDATA   = 3'd3,
        OP_WAIT_RB = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        STROBE    = 3'd2,
        HOLD      = 3'd3,
        BUSY_WAIT = 3'd4
    } state_t;

    localparam int T_WP_DEF        = 2;
    localparam int T_RP_DEF        = 2;
    localparam int T_WH_DEF        = 2;
    localparam int T_WB_DEF        = 4;
    localparam int TIMEOUT_CYC_DEF = 4096;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// nand_rb_sync: two-flop synchroniser for the asynchronous R/B# pin.
// Resets to 1 so the device is seen as ready until proven busy.
`timescale 1ns/1ps
module nand_rb_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rb_n,
    output logic o_rb_n
);

    logic [1:0] r_sync;

    // shift R/B# through two flops into the clk domain
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_rb_n};
    end

    assign o_rb_n = r_sync[1];

endmodule

// File: rtl/nand_bus_sequencer.sv
// nand_bus_sequencer: turns single-byte controller ops into timed NAND pin activity.
// Define NAND_SEQ_TIMEOUT_EN to bound BUSY_WAIT by TIMEOUT_CYC and flag rsp_err.
`timescale 1ns/1ps
module nand_bus_sequencer
    import nand_seq_pkg::*;
#(
    parameter int T_WP        = T_WP_DEF,
    parameter int T_RP        = T_RP_DEF,
    parameter int T_WH        = T_WH_DEF,
    parameter int T_WB        = T_WB_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       chip_en,
    output logic       ce_n,
    output logic       cle,
    output logic       ale,
    output logic       we_n,
    output logic       re_n,
    output logic [7:0] dq_out,
    output logic       dq_oe,
    input  logic [7:0] dq_in,
    input  logic       rb_n
);

    localparam int T_MAX = imax(imax(imax(T_WP, T_RP), imax(T_WH, T_WB)), TIMEOUT_CYC);
    localparam int CW    = $clog2(T_MAX) + 1;

    state_t        r_state;
    state_t        w_next;
    op_t           r_op;
    logic [7:0]    r_data;
    logic [CW-1:0] r_cnt;
    logic          r_wb_done;
    logic          r_ce_n;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [7:0]    r_rsp_data;
    logic          w_rb;
    logic          w_cnt_zero;
    logic          w_accept;
    logic          w_rsp_fire;
    logic          w_rsp_err;
    logic          w_active;
    logic          w_wr;

    nand_rb_sync u_rb_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_rb_n (rb_n),
        .o_rb_n (w_rb)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = req_valid && (r_state == IDLE);

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state decode; also flags the response pulse on exit edges
    always_comb begin
        w_next     = r_state;
        w_rsp_fire = 1'b0;
        w_rsp_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid)
                    w_next = (op_t'(req_op) == OP_WAIT_RB) ? BUSY_WAIT : SETUP;
            end
            SETUP: w_next = STROBE;
            STROBE: begin
                if (w_cnt_zero) begin
                    w_next     = HOLD;
                    w_rsp_fire = (r_op == OP_RDATA);
                end
            end
            HOLD: begin
                if (w_cnt_zero) w_next = IDLE;
            end
            BUSY_WAIT: begin
                if ((!r_wb_done && w_cnt_zero && w_rb) || (r_wb_done && w_rb)) begin
                    w_next     = IDLE;
                    w_rsp_fire = 1'b1;
                end
`ifdef NAND_SEQ_TIMEOUT_EN
                else if (r_wb_done && w_cnt_zero) begin
                    w_next     = IDLE;
                    w_rsp_fire = 1'b1;
                    w_rsp_err  = 1'b1;
                end
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // request latch, shared down-counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_CMD;
            r_data      <= '0;
            r_cnt       <= '0;
            r_wb_done   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rsp_fire;
            r_rsp_err   <= w_rsp_err;
            if (w_accept) begin
                r_op   <= op_t'(req_op);
                r_data <= req_data;
            end
            if (r_state == STROBE && w_cnt_zero && r_op == OP_RDATA)
                r_rsp_data <= dq_in;
            if (w_next != r_state) begin
                r_wb_done <= 1'b0;
                unique case (w_next)
                    STROBE:    r_cnt <= (r_op == OP_RDATA) ? CW'(T_RP - 1) : CW'(T_WP - 1);
                    HOLD:      r_cnt <= CW'(T_WH - 1);
                    BUSY_WAIT: r_cnt <= CW'(T_WB - 1);
                    default:   r_cnt <= '0;
                endcase
            end else if (r_state == BUSY_WAIT && !r_wb_done && w_cnt_zero) begin
                r_wb_done <= 1'b1;
                r_cnt     <= CW'(TIMEOUT_CYC - 1);
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // chip enable follows the controller one cycle late in every state
    always_ff @(posedge clk) begin
        if (rst) r_ce_n <= 1'b1;
        else     r_ce_n <= ~chip_en;
    end

    // pin decode from the current state and latched op
    always_comb begin
        w_active = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
        w_wr     = (r_op == OP_CMD) || (r_op == OP_ADDR) || (r_op == OP_WDATA);
        cle      = w_active && (r_op == OP_CMD);
        ale      = w_active && (r_op == OP_ADDR);
        dq_oe    = w_active && w_wr;
        dq_out   = dq_oe ? r_data : 8'h00;
        we_n     = !((r_state == STROBE) && w_wr);
        re_n     = !((r_state == STROBE) && (r_op == OP_RDATA));
    end

    assign req_ready = (r_state == IDLE);
    assign ce_n      = r_ce_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// tb_nand_bus_sequencer: scoreboard bench for nand_bus_sequencer.
// Build with NAND_SEQ_TIMEOUT_EN to also exercise the busy timeout.
`timescale 1ns/1ps
module tb_nand_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       chip_en = 1'b0;
    logic       ce_n;
    logic       cle;
    logic       ale;
    logic       we_n;
    logic       re_n;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic [7:0] dq_in;
    logic       rb_n = 1'b1;
    logic [7:0] dev_byte = 8'h00;

    localparam logic [2:0] C_CMD = 3'd0, C_ADDR = 3'd1, C_WDATA = 3'd2;
    localparam logic [2:0] C_RDATA = 3'd3, C_WAIT = 3'd4;
`ifdef NAND_SEQ_TIMEOUT_EN
    localparam int HOLD_LOW = 40;
`else
    localparam int HOLD_LOW = 100;
`endif

    always #5 clk = ~clk;

    assign dq_in = re_n ? 8'h00 : dev_byte;

    nand_bus_sequencer #(.TIMEOUT_CYC(50)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .chip_en   (chip_en),
        .ce_n      (ce_n),
        .cle       (cle),
        .ale       (ale),
        .we_n      (we_n),
        .re_n      (re_n),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dq_in     (dq_in),
        .rb_n      (rb_n)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic       is_read;
        logic       err;
        logic [7:0] data;
    } rsp_t;

    typedef struct {
        int         len;
        logic       cle_all;
        logic       cle_any;
        logic       ale_all;
        logic       ale_any;
        logic       oe_any;
        logic       stable;
        logic [7:0] b;
    } pulse_t;

    rsp_t   exp_q[$];
    pulse_t wq[$];
    pulse_t rq[$];
    int     cyc = 0;
    int     n_rsp = 0;
    int     rsp_cyc = 0;
    int     n_acc = 0;
    int     acc_cyc = 0;
    logic   bad_clale = 1'b0;
    logic   bad_re_oe = 1'b0;
    pulse_t wcur;
    pulse_t rcur;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !rst) n_acc <= n_acc + 1;
    end

    // response scoreboard
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_t e;
            n_rsp   = n_rsp + 1;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.is_read) chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    // strobe pulse recorder
    always @(negedge clk) begin
        if (cle && ale) bad_clale = 1'b1;
        if (!re_n && dq_oe) bad_re_oe = 1'b1;
        if (!we_n) begin
            if (wcur.len == 0) begin
                wcur.cle_all = 1'b1; wcur.cle_any = 1'b0;
                wcur.ale_all = 1'b1; wcur.ale_any = 1'b0;
                wcur.oe_any = 1'b0; wcur.stable = dq_oe; wcur.b = dq_out;
            end
            wcur.len++;
            wcur.cle_all &= cle; wcur.cle_any |= cle;
            wcur.ale_all &= ale; wcur.ale_any |= ale;
            wcur.stable &= (dq_out == wcur.b) && dq_oe;
        end else if (wcur.len > 0) begin
            wq.push_back(wcur);
            wcur.len = 0;
        end
        if (!re_n) begin
            if (rcur.len == 0) rcur.oe_any = 1'b0;
            rcur.len++;
            rcur.oe_any |= dq_oe;
        end else if (rcur.len > 0) begin
            rq.push_back(rcur);
            rcur.len = 0;
        end
    end

    // called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [2:0] op, input logic [7:0] d, input bit keep);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_wpulse(input string tag, input logic [7:0] b, input bit is_cmd);
        pulse_t p;
        if (wq.size() == 0) begin
            chk({tag, "_missing"}, 32'(wq.size()), 32'd1);
        end else begin
            p = wq.pop_front();
            chk({tag, "_len"}, 32'(p.len), 32'd2);
            chk({tag, "_byte"}, 32'(p.b), 32'(b));
            chk({tag, "_stable"}, 32'(p.stable), 32'd1);
            chk({tag, "_cle"}, 32'({p.cle_all, p.cle_any}), is_cmd ? 32'd3 : 32'd0);
            chk({tag, "_ale"}, 32'({p.ale_all, p.ale_any}), is_cmd ? 32'd0 : 32'd3);
        end
    endtask

    initial begin
        int n;
        int base;
        pulse_t p;
        wcur.len = 0;
        rcur.len = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_pins", 32'({ce_n, cle, ale, we_n, re_n, dq_oe}), 32'b100110);
        chk("rst_dq", 32'({dq_out, rsp_data}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        rst = 1'b0;
        chk_en_on: chip_en = 1'b1;
        @(negedge clk);
        chk("ce_n_on", 32'(ce_n), 32'd0);

        // CMD 0x70
        send(C_CMD, 8'h70, 1'b0);
        chk("cmd_setup", 32'({cle, ale, we_n, dq_oe, dq_out}), 32'({4'b1011, 8'h70}));
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_latency", 32'(n), 32'd5);
        chk("cmd_idle_pins", 32'({cle, ale, dq_oe}), 32'd0);
        chk_wpulse("cmd", 8'h70, 1'b0 == 1'b0);

        // three back-to-back ADDR bytes; valid held high while stalled
        base = n_acc;
        send(C_ADDR, 8'h00, 1'b1);
        send(C_ADDR, 8'h00, 1'b1);
        send(C_ADDR, 8'h05, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("addr_accepts", 32'(n_acc - base), 32'd3);
        chk_wpulse("addr0", 8'h00, 1'b0);
        chk_wpulse("addr1", 8'h00, 1'b0);
        chk_wpulse("addr2", 8'h05, 1'b0);

        // reads, device returns its byte while RE# is low
        dev_byte = 8'hA5;
        exp_q.push_back('{is_read: 1'b1, err: 1'b0, data: 8'hA5});
        send(C_RDATA, 8'h00, 1'b0);
        chk("rd_setup_oe", 32'(dq_oe), 32'd0);
        wait_idle();
        dev_byte = 8'h3C;
        exp_q.push_back('{is_read: 1'b1, err: 1'b0, data: 8'h3C});
        send(C_RDATA, 8'h00, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("rd_pulses", 32'(rq.size()), 32'd2);
        while (rq.size() > 0) begin
            p = rq.pop_front();
            chk("rd_len", 32'(p.len), 32'd2);
            chk("rd_oe", 32'(p.oe_any), 32'd0);
        end
        chk("rd_rsp_count", 32'(n_rsp), 32'd2);

        // WAIT_RB with R/B# already ready: completes right after T_WB
        exp_q.push_back('{is_read: 1'b0, err: 1'b0, data: 8'h00});
        base = n_rsp;
        send(C_WAIT, 8'h00, 1'b0);
        n = 0;
        while (n_rsp == base && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_fast_lat", 32'(rsp_cyc - acc_cyc), 32'd4);
        chk("wait_fast_ready", 32'(req_ready), 32'd1);

        // WAIT_RB with device busy, then released
        rb_n = 1'b0;
        exp_q.push_back('{is_read: 1'b0, err: 1'b0, data: 8'h00});
        base = n_rsp;
        send(C_WAIT, 8'h00, 1'b0);
        repeat (HOLD_LOW) @(negedge clk);
        chk("wait_no_early", 32'(n_rsp), 32'(base));
        rb_n = 1'b1;
        n = cyc;
        while (n_rsp == base && cyc - n < 20) @(negedge clk);
        chk("wait_rel_lat", 32'((rsp_cyc - n >= 2) && (rsp_cyc - n <= 3)), 32'd1);

`ifdef NAND_SEQ_TIMEOUT_EN
        // R/B# stuck busy: timeout after T_WB + TIMEOUT_CYC
        @(negedge clk);
        rb_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back('{is_read: 1'b0, err: 1'b1, data: 8'h00});
        base = n_rsp;
        send(C_WAIT, 8'h00, 1'b0);
        n = 0;
        while (n_rsp == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_lat", 32'(rsp_cyc - acc_cyc), 32'd54);
        chk("to_ready", 32'(req_ready), 32'd1);
        rb_n = 1'b1;
        repeat (3) @(negedge clk);
`endif

        // reset during the WE# strobe of a write
        wait_idle();
        base = n_rsp;
        send(C_WDATA, 8'h5A, 1'b0);
        @(negedge clk);
        chk("wd_strobe", 32'({we_n, dq_oe, dq_out}), 32'({2'b01, 8'h5A}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_pins", 32'({we_n, dq_oe, req_ready}), 32'b101);
        repeat (6) @(negedge clk);
        chk("rst_mid_norsp", 32'(n_rsp), 32'(base));
        wq.delete();

        // write after the aborted one still works
        send(C_WDATA, 8'hC3, 1'b0);
        wait_idle();
        @(negedge clk);
        if (wq.size() > 0) begin
            p = wq.pop_front();
            chk("wd_byte", 32'({p.b, p.cle_any, p.ale_any}), 32'({8'hC3, 2'b00}));
        end else begin
            chk("wd_missing", 32'(wq.size()), 32'd1);
        end

        chip_en = 1'b0;
        @(negedge clk);
        chk("ce_n_off", 32'(ce_n), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("cle_ale_excl", 32'(bad_clale), 32'd0);
        chk("re_oe_excl", 32'(bad_re_oe), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
